// File: rtl/vscale_ahb_decoder.sv
// Single-master AHB-Lite address decoder and response multiplexer with a built-in
// default slave that answers unmapped transfers with the two-cycle ERROR response.
//
// state    | meaning
// ERR_IDLE | no error response in progress
// ERR_1    | first ERROR cycle: hready low, hresp high
// ERR_2    | second ERROR cycle: hready high, hresp high
module vscale_ahb_decoder #(
    parameter int                      N_SLAVES   = 4,
    parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK = {N_SLAVES{32'hFFFF_F000}},
    parameter int                      ERR_CNT_W  = 8
) (
    input  logic                     hclk,
    input  logic                     hresetn,

    input  logic [31:0]              m_haddr,
    input  logic                     m_hwrite,
    input  logic [2:0]               m_hsize,
    input  logic [2:0]               m_hburst,
    input  logic                     m_hmastlock,
    input  logic [3:0]               m_hprot,
    input  logic [1:0]               m_htrans,
    input  logic [31:0]              m_hwdata,
    output logic [31:0]              m_hrdata,
    output logic                     m_hready,
    output logic                     m_hresp,

    output logic [N_SLAVES-1:0]      s_hsel,
    output logic [31:0]              s_haddr,
    output logic                     s_hwrite,
    output logic [2:0]               s_hsize,
    output logic [2:0]               s_hburst,
    output logic                     s_hmastlock,
    output logic [3:0]               s_hprot,
    output logic [1:0]               s_htrans,
    output logic [31:0]              s_hwdata,
    output logic                     s_hready,
    input  logic [N_SLAVES*32-1:0]   s_hrdata,
    input  logic [N_SLAVES-1:0]      s_hreadyout,
    input  logic [N_SLAVES-1:0]      s_hresp,

    output logic [ERR_CNT_W-1:0]     err_count
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {OWN_NONE, OWN_SLAVE, OWN_DEFAULT} owner_t;
    typedef enum logic [1:0] {ERR_IDLE, ERR_1, ERR_2} err_state_t;

    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;
    logic [N_SLAVES-1:0]  hsel;
    logic                 active;
    logic                 miss_accept;

    owner_t               owner_q;
    logic [IDX_W-1:0]     owner_idx_q;
    err_state_t           err_state;
    err_state_t           err_next;

    // Walk from the highest index down so the lowest matching slave wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hsel    = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_haddr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
                hsel    = N_SLAVES'(1) << i;
            end
        end
    end

    assign active      = m_htrans[1];
    assign miss_accept = m_hready & active & ~hit;

    assign s_hsel      = hsel;
    assign s_haddr     = m_haddr;
    assign s_hwrite    = m_hwrite;
    assign s_hsize     = m_hsize;
    assign s_hburst    = m_hburst;
    assign s_hmastlock = m_hmastlock;
    assign s_hprot     = m_hprot;
    assign s_htrans    = m_htrans;
    assign s_hwdata    = m_hwdata;
    assign s_hready    = m_hready;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            owner_q     <= OWN_NONE;
            owner_idx_q <= '0;
        end else if (m_hready) begin
            if (!active) begin
                owner_q <= OWN_NONE;
            end else if (hit) begin
                owner_q     <= OWN_SLAVE;
                owner_idx_q <= hit_idx;
            end else begin
                owner_q <= OWN_DEFAULT;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            err_state <= ERR_IDLE;
        end else begin
            err_state <= err_next;
        end
    end

    always_comb begin
        err_next = ERR_IDLE;
        case (err_state)
            ERR_IDLE: err_next = miss_accept ? ERR_1 : ERR_IDLE;
            ERR_1:    err_next = ERR_2;
            ERR_2:    err_next = miss_accept ? ERR_1 : ERR_IDLE;
            default:  err_next = ERR_IDLE;
        endcase
    end

    // A miss can only be accepted while hready is high, so every accepted miss is an ERR_1 entry.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            err_count <= '0;
        end else if (miss_accept && !(&err_count)) begin
            err_count <= err_count + 1'b1;
        end
    end

    always_comb begin
        m_hready = 1'b1;
        m_hresp  = 1'b0;
        m_hrdata = '0;
        case (owner_q)
            OWN_SLAVE: begin
                for (int i = 0; i < N_SLAVES; i++) begin
                    if (owner_idx_q == IDX_W'(i)) begin
                        m_hrdata = s_hrdata[i*32 +: 32];
                        m_hready = s_hreadyout[i];
                        m_hresp  = s_hresp[i];
                    end
                end
            end
            OWN_DEFAULT: begin
                m_hready = (err_state != ERR_1);
                m_hresp  = 1'b1;
            end
            default: begin
                m_hready = 1'b1;
                m_hresp  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vscale_ahb_decoder.sv
// Bench for vscale_ahb_decoder: a transfer-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vscale_ahb_decoder;

    localparam logic [31:0] MB [0:1] = '{32'h0000_0000, 32'h2000_0000};
    localparam logic [31:0] MM [0:1] = '{32'hFFFF_0000, 32'hFFFF_0000};
    localparam int CNT_MAX = 3;
    localparam int K_NONE = 0;
    localparam int K_SLV  = 1;
    localparam int K_ERR  = 2;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic [31:0] m_haddr = '0;
    logic        m_hwrite = 1'b0;
    logic [2:0]  m_hsize = 3'd2;
    logic [2:0]  m_hburst = 3'd0;
    logic        m_hmastlock = 1'b0;
    logic [3:0]  m_hprot = 4'h3;
    logic [1:0]  m_htrans = 2'd0;
    logic [31:0] m_hwdata = '0;
    logic [31:0] m_hrdata;
    logic        m_hready;
    logic        m_hresp;
    logic [1:0]  s_hsel;
    logic [31:0] s_haddr;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [2:0]  s_hburst;
    logic        s_hmastlock;
    logic [3:0]  s_hprot;
    logic [1:0]  s_htrans;
    logic [31:0] s_hwdata;
    logic        s_hready;
    logic [63:0] s_hrdata = {32'h1111_1111, 32'hDEAD_BEEF};
    logic [1:0]  s_hreadyout = 2'b11;
    logic [1:0]  s_hresp = 2'b00;
    logic [1:0]  err_count;

    logic [31:0] o_hrdata;
    logic        o_hready, o_hresp, o_hwrite, o_hmastlock, o_hready_s;
    logic [1:0]  o_hsel, o_htrans;
    logic [31:0] o_haddr, o_hwdata;
    logic [2:0]  o_hsize, o_hburst;
    logic [3:0]  o_hprot;
    logic [7:0]  o_err_count;

    int checks = 0;
    int errors = 0;
    int mk = K_NONE;
    int mi = 0;
    int mph = 0;
    int mcnt = 0;
    int lowcnt;

    always #5 hclk = ~hclk;

    vscale_ahb_decoder #(
        .N_SLAVES(2),
        .SLAVE_BASE({32'h2000_0000, 32'h0000_0000}),
        .SLAVE_MASK({32'hFFFF_0000, 32'hFFFF_0000}),
        .ERR_CNT_W(2)
    ) dut (
        .hclk(hclk), .hresetn(hresetn),
        .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
        .m_hmastlock(m_hmastlock), .m_hprot(m_hprot), .m_htrans(m_htrans), .m_hwdata(m_hwdata),
        .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
        .s_hsel(s_hsel), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans),
        .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hrdata(s_hrdata),
        .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .err_count(err_count)
    );

    // Overlapping windows: slave0 0x0000_xxxx, slave1 any address with bits [15:12] zero.
    vscale_ahb_decoder #(
        .N_SLAVES(2),
        .SLAVE_BASE(64'h0),
        .SLAVE_MASK({32'h0000_F000, 32'hFFFF_0000}),
        .ERR_CNT_W(8)
    ) u_ovl (
        .hclk(hclk), .hresetn(hresetn),
        .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
        .m_hmastlock(m_hmastlock), .m_hprot(m_hprot), .m_htrans(m_htrans), .m_hwdata(m_hwdata),
        .m_hrdata(o_hrdata), .m_hready(o_hready), .m_hresp(o_hresp),
        .s_hsel(o_hsel), .s_haddr(o_haddr), .s_hwrite(o_hwrite), .s_hsize(o_hsize),
        .s_hburst(o_hburst), .s_hmastlock(o_hmastlock), .s_hprot(o_hprot), .s_htrans(o_htrans),
        .s_hwdata(o_hwdata), .s_hready(o_hready_s), .s_hrdata(s_hrdata),
        .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .err_count(o_err_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 2; i++)
            if ((a & MM[i]) == MB[i]) return i;
        return -1;
    endfunction

    function automatic logic model_ready();
        if (mk == K_SLV) return s_hreadyout[mi];
        if (mk == K_ERR) return (mph == 1);
        return 1'b1;
    endfunction

    function automatic logic model_resp();
        if (mk == K_SLV) return s_hresp[mi];
        return (mk == K_ERR);
    endfunction

    function automatic logic [31:0] model_rdata();
        if (mk == K_SLV) return s_hrdata[mi*32 +: 32];
        return 32'h0;
    endfunction

    function automatic logic [1:0] model_hsel();
        int d;
        d = decode(m_haddr);
        if (d < 0) return 2'b00;
        return (d == 0) ? 2'b01 : 2'b10;
    endfunction

    // Transfer-level model: who owns the current data phase, and how far an error response has got.
    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            mk   <= K_NONE;
            mi   <= 0;
            mph  <= 0;
            mcnt <= 0;
        end else if (mk == K_ERR && mph == 0) begin
            mph <= 1;
        end else if (model_ready()) begin
            if (m_htrans == 2'd2 || m_htrans == 2'd3) begin
                if (decode(m_haddr) >= 0) begin
                    mk <= K_SLV;
                    mi <= decode(m_haddr);
                end else begin
                    mk   <= K_ERR;
                    mph  <= 0;
                    mcnt <= (mcnt < CNT_MAX) ? mcnt + 1 : CNT_MAX;
                end
            end else begin
                mk <= K_NONE;
            end
        end
    end

    always @(negedge hclk) begin
        chk("m_hready", 32'(m_hready), 32'(model_ready()));
        chk("m_hresp", 32'(m_hresp), 32'(model_resp()));
        chk("m_hrdata", m_hrdata, model_rdata());
        chk("s_hsel", 32'(s_hsel), 32'(model_hsel()));
        chk("err_count", 32'(err_count), 32'(mcnt));
        chk("s_hready", 32'(s_hready), 32'(model_ready()));
        chk("s_haddr", s_haddr, m_haddr);
        chk("s_hwdata", s_hwdata, m_hwdata);
        chk("s_htrans", 32'(s_htrans), 32'(m_htrans));
    end

    task automatic drive(input logic [31:0] a, input logic [1:0] t);
        m_haddr  = a;
        m_htrans = t;
        m_hwdata = 32'hA5A5_0000 ^ a;
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(32'h4000_0000, 2'd0);
        @(negedge hclk);
        chk("rst_hready", 32'(m_hready), 32'd1);
        chk("rst_hresp", 32'(m_hresp), 32'd0);
        chk("rst_hrdata", m_hrdata, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_hsel_miss", 32'(s_hsel), 32'd0);
        m_haddr = 32'h0000_0004;
        #1;
        chk("rst_hsel_follow", 32'(s_hsel), 32'h1);
        cyc();
        hresetn = 1'b1;

        // BUSY to an unmapped address: no error, no count
        drive(32'h4000_0000, 2'd1);
        cyc();
        drive(32'h0000_0004, 2'd2);
        @(negedge hclk);
        chk("busy_hresp", 32'(m_hresp), 32'd0);
        chk("busy_err_count", 32'(err_count), 32'd0);
        chk("rd0_hsel", 32'(s_hsel), 32'h1);

        // read slave0
        cyc();
        drive(32'h0, 2'd0);
        @(negedge hclk);
        chk("rd0_hrdata", m_hrdata, 32'hDEAD_BEEF);
        chk("rd0_hready", 32'(m_hready), 32'd1);
        chk("rd0_hresp", 32'(m_hresp), 32'd0);

        // slave1 inserts three wait states
        cyc();
        drive(32'h2000_0010, 2'd2);
        s_hreadyout[1] = 1'b0;
        @(negedge hclk);
        chk("rd1_hsel", 32'(s_hsel), 32'h2);
        cyc();
        drive(32'h0000_0008, 2'd2);
        lowcnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) s_hreadyout[1] = 1'b1;
            @(negedge hclk);
            if (m_hready) break;
            lowcnt++;
            cyc();
        end
        chk("wait_low_cycles", 32'(lowcnt), 32'd3);
        chk("wait_hrdata", m_hrdata, 32'h1111_1111);
        cyc();
        drive(32'h0, 2'd0);
        @(negedge hclk);
        chk("after_wait_hrdata", m_hrdata, 32'hDEAD_BEEF);

        // single unmapped access
        cyc();
        drive(32'h4000_0000, 2'd2);
        cyc();
        drive(32'h0, 2'd0);
        @(negedge hclk);
        chk("err1_hready", 32'(m_hready), 32'd0);
        chk("err1_hresp", 32'(m_hresp), 32'd1);
        cyc();
        @(negedge hclk);
        chk("err2_hready", 32'(m_hready), 32'd1);
        chk("err2_hresp", 32'(m_hresp), 32'd1);
        chk("err_count_one", 32'(err_count), 32'd1);
        cyc();

        // six back-to-back unmapped NONSEQs, saturating a 2-bit counter
        drive(32'h4000_0100, 2'd2);
        for (int i = 0; i < 6; i++) begin
            cyc();
            @(negedge hclk);
            chk("b2b_err1_hready", 32'(m_hready), 32'd0);
            chk("b2b_err1_hresp", 32'(m_hresp), 32'd1);
            cyc();
            if (i == 5) drive(32'h4000_0000, 2'd0);
            @(negedge hclk);
            chk("b2b_err2_hready", 32'(m_hready), 32'd1);
            chk("b2b_err2_hresp", 32'(m_hresp), 32'd1);
        end
        chk("err_count_sat", 32'(err_count), 32'd3);
        cyc();
        @(negedge hclk);
        chk("post_sat_hresp", 32'(m_hresp), 32'd0);
        chk("post_sat_count", 32'(err_count), 32'd3);

        // overlapping windows
        cyc();
        drive(32'h0000_0100, 2'd0);
        #1;
        chk("ovl_hsel_both", 32'(o_hsel), 32'h1);
        m_haddr = 32'h0001_0100;
        #1;
        chk("ovl_hsel_one", 32'(o_hsel), 32'h2);
        chk("main_hsel_miss", 32'(s_hsel), 32'h0);

        // reset during ERR1
        cyc();
        drive(32'h4000_0000, 2'd2);
        cyc();
        drive(32'h0, 2'd0);
        #1;
        chk("pre_rst_hready", 32'(m_hready), 32'd0);
        hresetn = 1'b0;
        #1;
        chk("midrst_hready", 32'(m_hready), 32'd1);
        chk("midrst_hresp", 32'(m_hresp), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        cyc();
        hresetn = 1'b1;
        drive(32'h2000_0004, 2'd2);
        cyc();
        drive(32'h0, 2'd0);
        @(negedge hclk);
        chk("post_rst_hrdata", m_hrdata, 32'h1111_1111);
        chk("post_rst_hready", 32'(m_hready), 32'd1);
        chk("post_rst_hresp", 32'(m_hresp), 32'd0);
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
